bcd_game_timer: RTL

//   Parametrised BCD game timer: DIGITS-digit packed-BCD counter with built-in tick divider,

---
 rtl/bcd_game_timer_if.sv | 32 +++
 rtl/bcd_game_timer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/bcd_game_timer_if.sv
// Control/status bundle between the game FSM (master) and the BCD timer (slave).
// The game FSM drives the load/start/pause controls. The timer returns the packed-BCD
// count and its status strobes.
interface bcd_game_timer_if #(
  parameter int DIGITS = 2
);

  logic                  Load;
  logic [4*DIGITS-1:0]   LoadValue;
  logic                  Start;
  logic                  Pause;
  logic                  CountUp;

  logic [4*DIGITS-1:0]   Digits;
  logic                  Tick;
  logic                  Running;
  logic                  Done;
  logic                  Expired;

  // Game FSM side
  modport master (
    output Load, LoadValue, Start, Pause, CountUp,
    input  Digits, Tick, Running, Done, Expired
  );

  // Timer side
  modport slave (
    input  Load, LoadValue, Start, Pause, CountUp,
    output Digits, Tick, Running, Done, Expired
  );

endinterface

// File: rtl/bcd_game_timer.sv
// BCD game timer: a DIGITS-digit packed-BCD counter with a built-in tick divider.
// It counts down from the Limit register to zero, or up from zero to Limit.
// It supports pause, runtime load of Limit, and a one-cycle Done pulse on reaching the end.
// Digits are registered and feed the HEX display decoders directly.
module bcd_game_timer #(
  parameter int                  CLK_FREQ    = 50_000_000,
  parameter int                  TICK_FREQ   = 1,
  parameter int                  DIGITS      = 2,
  parameter logic [4*DIGITS-1:0] DEFAULT_BCD = (4*DIGITS)'(32'h60)
) (
  input  logic                 CLOCK_50,
  input  logic                 Reset,
  bcd_game_timer_if.slave      bus
);

  localparam int W        = 4 * DIGITS;
  localparam int DIV      = CLK_FREQ / TICK_FREQ;
  localparam int DIVW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    EXPIRED
  } state_t;

  // Force every nibble into 0..9 so that a bad load value can never reach the display.
  function automatic logic [W-1:0] clampBcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd9;
      end
    end
    return r;
  endfunction

  // Ripple-borrow decrement. A zero digit wraps to 9 and passes the borrow upward.
  function automatic logic [W-1:0] bcdDec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Ripple-carry increment. A digit at 9 (or above) wraps to 0 and passes the carry upward.
  function automatic logic [W-1:0] bcdInc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // The reset value is clamped as well, so a malformed DEFAULT_BCD still shows legal digits.
  localparam logic [W-1:0] RESET_BCD = clampBcd(DEFAULT_BCD);

  state_t         state_q;
  logic [W-1:0]   limit_q;
  logic [W-1:0]   digits_q;
  logic [DIVW-1:0] div_q;
  logic           countUp_q;
  logic           tick_q;
  logic           done_q;

  logic [W-1:0]   loadValue_d;
  logic [W-1:0]   startDigits_d;
  logic [W-1:0]   startTerm_d;
  logic [W-1:0]   terminal_d;
  logic [W-1:0]   stepped_d;

  // Candidate values for the next edge: the clamped load, the start point and end point
  // of a fresh count, the current end point, and the count after one step.
  always_comb begin
    loadValue_d   = clampBcd(bus.LoadValue);
    startDigits_d = bus.CountUp ? '0 : limit_q;
    startTerm_d   = bus.CountUp ? limit_q : '0;
    terminal_d    = countUp_q ? limit_q : '0;
    stepped_d     = countUp_q ? bcdInc(digits_q) : bcdDec(digits_q);
  end

  // Timer FSM. Each edge takes the first that applies of: reset, load, start, pause, tick.
  always_ff @(posedge CLOCK_50) begin
    if (!Reset) begin
      state_q   <= IDLE;
      limit_q   <= RESET_BCD;
      digits_q  <= RESET_BCD;
      div_q     <= '0;
      countUp_q <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      if (bus.Load) begin
        limit_q  <= loadValue_d;
        digits_q <= loadValue_d;
        div_q    <= '0;
        state_q  <= IDLE;
      end else if (bus.Start) begin
        countUp_q <= bus.CountUp;
        div_q     <= '0;
        digits_q  <= startDigits_d;
        if (startDigits_d == startTerm_d) begin
          state_q <= EXPIRED;
          done_q  <= 1'b1;
        end else begin
          state_q <= RUN;
        end
      end else begin
        case (state_q)
          RUN: begin
            if (bus.Pause) begin
              state_q <= PAUSED;
            end else if (div_q == DIV_LAST) begin
              div_q    <= '0;
              tick_q   <= 1'b1;
              digits_q <= stepped_d;
              if (stepped_d == terminal_d) begin
                state_q <= EXPIRED;
                done_q  <= 1'b1;
              end
            end else begin
              div_q <= div_q + DIVW'(1);
            end
          end
          PAUSED: begin
            if (!bus.Pause) begin
              state_q <= RUN;
            end
          end
          default: begin
            state_q <= state_q;
          end
        endcase
      end
    end
  end

  assign bus.Digits  = digits_q;
  assign bus.Tick    = tick_q;
  assign bus.Done    = done_q;
  assign bus.Running = (state_q == RUN);
  assign bus.Expired = (state_q == EXPIRED);

endmodule
